alu_mc: RTL

//  Multi-cycle, parametrised ALU; successor to the single-cycle 3-bit-op ALU.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_muldiv.sv | 85 ++++++++
 rtl/alu_mc.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// done is high during the final iteration; lo/hi then carry the finished result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  logic                  busy;
  logic                  div_mode;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   rem_diff;
  logic [DATA_WIDTH-1:0] nxt_hi;
  logic [DATA_WIDTH-1:0] nxt_lo;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, operand};
  assign rem_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
  // Partial remainder stays below the divisor, so bit W of the difference is the borrow.
  assign rem_diff  = rem_shift - {1'b0, operand};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (div_mode) begin
      if (!rem_diff[DATA_WIDTH]) begin
        nxt_hi = rem_diff[DATA_WIDTH-1:0];
        nxt_lo = {acc_lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_shift[DATA_WIDTH-1:0];
        nxt_lo = {acc_lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {nxt_hi, nxt_lo} = {mul_sum, acc_lo[DATA_WIDTH-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[DATA_WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CNT_W'(DATA_WIDTH - 1));
  assign lo   = nxt_lo;
  assign hi   = nxt_hi;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      div_mode <= 1'b0;
      operand  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      div_mode <= is_div;
      operand  <= b;
      acc_hi   <= '0;
      acc_lo   <= a;
      cnt      <= '0;
    end else if (busy) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: handshake FSM, single-cycle adder/logic ops and
// registered result/flag outputs; MUL/DIV are delegated to alu_muldiv.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  state_t state, state_nxt;

  logic                  fire;
  logic                  op_muldiv;
  logic                  sub_op;
  logic [DATA_WIDTH-1:0] b_opnd;
  logic [DATA_WIDTH:0]   sum;
  logic                  ovf_add;
  logic                  ovf_sub;
  logic [DATA_WIDTH-1:0] s_result;
  logic                  s_ovf;
  logic                  s_cout;
  logic                  md_done;
  logic [DATA_WIDTH-1:0] md_lo;
  logic [DATA_WIDTH-1:0] md_hi;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign fire      = in_valid && in_ready;
  assign op_muldiv = is_muldiv(ALUop);

  assign sub_op  = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
  assign b_opnd  = sub_op ? ~B : B;
  assign sum     = {1'b0, A} + {1'b0, b_opnd} + {{DATA_WIDTH{1'b0}}, sub_op};
  assign ovf_add = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  assign ovf_sub = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

  always_comb begin
    s_result = '0;
    s_ovf    = 1'b0;
    s_cout   = 1'b0;
    case (ALUop)
      OP_AND: s_result = A & B;
      OP_OR:  s_result = A | B;
      OP_XOR: s_result = A ^ B;
      OP_NOR: s_result = ~(A | B);
      OP_ADD: begin
        s_result = sum[DATA_WIDTH-1:0];
        s_cout   = sum[DATA_WIDTH];
        s_ovf    = ovf_add;
      end
      OP_SUB: begin
        s_result = sum[DATA_WIDTH-1:0];
        s_cout   = sum[DATA_WIDTH];
        s_ovf    = ovf_sub;
      end
      OP_SLT: begin
        s_result = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ ovf_sub};
        s_cout   = sum[DATA_WIDTH];
        s_ovf    = ovf_sub;
      end
      OP_SLTU: begin
        s_result = {{(DATA_WIDTH-1){1'b0}}, ~sum[DATA_WIDTH]};
        s_cout   = sum[DATA_WIDTH];
      end
      default: ;
    endcase
  end

  alu_muldiv #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (fire && op_muldiv),
    .is_div(ALUop == OP_DIVU),
    .a     (A),
    .b     (B),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fire) state_nxt = op_muldiv ? S_BUSY : S_DONE;
      S_BUSY:  if (md_done) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Outputs only change when a result lands, so they hold steady through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      Result   <= '0;
      ResultHi <= '0;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else if (fire && !op_muldiv) begin
      Result   <= s_result;
      ResultHi <= '0;
      Overflow <= s_ovf;
      CarryOut <= s_cout;
      Zero     <= (s_result == '0);
    end else if ((state == S_BUSY) && md_done) begin
      Result   <= md_lo;
      ResultHi <= md_hi;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
      Zero     <= (md_lo == '0);
    end
  end

endmodule
